// File: rtl/daug_dram_ctrl.sv
// DRAM controller for the daughterboard control store / expansion RAM.
// Banked row/column multiplexing, byte CAS, CBR refresh and a sticky write-protect latch.
module daug_dram_ctrl #(
  parameter int unsigned ROW_W    = 8,
  parameter int unsigned BANK_W   = 1,
  parameter int unsigned CAS_WAIT = 0,
  parameter int unsigned PRE_CYC  = 2,
  parameter int unsigned REF_DIV  = 56,
  parameter int unsigned REF_HOLD = 2
) (
  input  logic                      CLK,
  input  logic                      _RST,
  input  logic                      SEL,
  input  logic [2*ROW_W+BANK_W-1:0] A,
  input  logic                      _AS,
  input  logic                      _UDS,
  input  logic                      _LDS,
  input  logic                      _PRW,
  input  logic                      LOCK,
  output logic [ROW_W-1:0]          MA,
  output logic [(1<<BANK_W)-1:0]    _RAS,
  output logic                      _UCAS,
  output logic                      _LCAS,
  output logic                      _WE,
  output logic                      _DTACK,
  output logic                      _DRD,
  output logic                      _DWR,
  output logic                      _WPRO
);

  localparam int unsigned NBANKS  = 1 << BANK_W;
  localparam int unsigned MAX1    = (CAS_WAIT > PRE_CYC) ? CAS_WAIT : PRE_CYC;
  localparam int unsigned CNT_MAX = (MAX1 > REF_HOLD) ? MAX1 : REF_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W   = $clog2(REF_DIV);

  typedef enum logic [2:0] {IDLE, ROW, COL, ACK, PRE, REF1, REF2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q;
  logic               pend_q, pend_clr;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0]   col_q, col_d;
  logic               uds_q, uds_d, lds_q, lds_d, prw_q, prw_d;
  logic [ROW_W-1:0]   ma_d;
  logic [NBANKS-1:0]  ras_d;
  logic               ucas_d, lcas_d, we_d, dtack_d, drd_d, dwr_d;
  logic               req, wp;

  assign wp  = ~_WPRO;
  assign req = SEL & ~_AS & (~_UDS | ~_LDS) & _DTACK;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_clr = 1'b0;
    bank_d   = bank_q;
    col_d    = col_q;
    uds_d    = uds_q;
    lds_d    = lds_q;
    prw_d    = prw_q;
    ma_d     = MA;
    ras_d    = _RAS;
    ucas_d   = _UCAS;
    lcas_d   = _LCAS;
    we_d     = _WE;
    dtack_d  = _DTACK;
    drd_d    = _DRD;
    dwr_d    = _DWR;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          ucas_d  = 1'b0;
          lcas_d  = 1'b0;
          state_d = REF1;
        end else if (req) begin
          bank_d  = A[2*ROW_W+BANK_W-1:2*ROW_W];
          col_d   = A[ROW_W-1:0];
          uds_d   = _UDS;
          lds_d   = _LDS;
          prw_d   = _PRW;
          ma_d    = A[2*ROW_W-1:ROW_W];
          state_d = ROW;
        end
      end
      ROW: begin
        ras_d[bank_q] = 1'b0;
        ma_d          = col_q;
        we_d          = prw_q | wp;
        dwr_d         = prw_q | wp;
        cnt_d         = '0;
        state_d       = COL;
      end
      COL: begin
        ucas_d = uds_q;
        lcas_d = lds_q;
        drd_d  = ~prw_q;
        if (cnt_q == CNT_W'(CAS_WAIT)) state_d = ACK;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      ACK: begin
        // An early-released _AS skips the acknowledge and releases directly.
        if (_AS) begin
          ras_d   = '1;
          ucas_d  = 1'b1;
          lcas_d  = 1'b1;
          we_d    = 1'b1;
          drd_d   = 1'b1;
          dwr_d   = 1'b1;
          dtack_d = 1'b1;
          cnt_d   = '0;
          state_d = PRE;
        end else begin
          dtack_d = 1'b0;
        end
      end
      PRE: begin
        if (cnt_q == CNT_W'(PRE_CYC - 1)) state_d = IDLE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      REF1: begin
        ras_d   = '0;
        cnt_d   = '0;
        state_d = REF2;
      end
      REF2: begin
        if (cnt_q == CNT_W'(REF_HOLD - 1)) begin
          ras_d    = '1;
          ucas_d   = 1'b1;
          lcas_d   = 1'b1;
          pend_clr = 1'b1;
          cnt_d    = '0;
          state_d  = PRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      col_q   <= '0;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      prw_q   <= 1'b1;
      MA      <= '0;
      _RAS    <= '1;
      _UCAS   <= 1'b1;
      _LCAS   <= 1'b1;
      _WE     <= 1'b1;
      _DTACK  <= 1'b1;
      _DRD    <= 1'b1;
      _DWR    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      col_q   <= col_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      prw_q   <= prw_d;
      MA      <= ma_d;
      _RAS    <= ras_d;
      _UCAS   <= ucas_d;
      _LCAS   <= lcas_d;
      _WE     <= we_d;
      _DTACK  <= dtack_d;
      _DRD    <= drd_d;
      _DWR    <= dwr_d;
    end
  end

  // Clearing pend wins over a coincident divider tick: that tick is dropped.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      div_q  <= DIV_W'(REF_DIV - 1);
      pend_q <= 1'b0;
      _WPRO  <= 1'b1;
    end else begin
      if (div_q == '0) div_q <= DIV_W'(REF_DIV - 1);
      else             div_q <= div_q - 1'b1;
      if (pend_clr)          pend_q <= 1'b0;
      else if (div_q == '0)  pend_q <= 1'b1;
      _WPRO <= _WPRO & ~LOCK;
    end
  end

endmodule
